// File: rtl/multdiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: FSM states, op select
// codes and the most-negative-integer pattern helper.
package multdiv_pkg;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_MULT = 3'd1;
   localparam logic [2:0] ST_DIV  = 3'd2;
   localparam logic [2:0] ST_FIX  = 3'd3;
   localparam logic [2:0] ST_DONE = 3'd4;

   typedef enum logic [2:0] {
      IDLE = ST_IDLE,
      MULT = ST_MULT,
      DIV  = ST_DIV,
      FIX  = ST_FIX,
      DONE = ST_DONE
   } state_t;

   localparam logic OP_MULT = 1'b0;
   localparam logic OP_DIV  = 1'b1;

   localparam int MAX_W = 128;

   // Only bit w-1 set; callers truncate to their own width.
   function automatic logic [MAX_W-1:0] min_int(input int w);
      return {{(MAX_W-1){1'b0}}, 1'b1} << (w - 1);
   endfunction

endpackage

// File: rtl/multdiv_step_ctr.sv
// Iteration counter shared by the Booth multiplier and restoring divider;
// term flags the last step (count == WIDTH-1).
module multdiv_step_ctr #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             load,
   input  logic             en,
   input  logic [CNT_W-1:0] load_val,
   output logic [CNT_W-1:0] count,
   output logic             term
);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)    count <= '0;
      else if (clear) count <= '0;
      else if (load)  count <= load_val;
      else if (en)    count <= count + 1'b1;
   end

   assign term = (count == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/multdiv_unit_p.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) unit with
// start/ready handshake and abort. MULTDIV_REM_EN adds the registered remainder port.
module multdiv_unit_p
   import multdiv_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start_mult,
   input  logic             start_div,
   input  logic             abort,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   output logic [WIDTH-1:0] result,
   output logic             exception,
   output logic             busy,
   output logic             ready
`ifdef MULTDIV_REM_EN
  ,output logic [WIDTH-1:0] remainder
`endif
);

   localparam logic [WIDTH-1:0] MIN_INT = WIDTH'(min_int(WIDTH));

   state_t               state;
   logic                 op;
   logic [2*WIDTH-1:0]   acc;      // mult: {hi, multiplier}; div: {partial rem, dividend/quotient}
   logic                 qm1;
   logic [WIDTH-1:0]     opnd;     // multiplicand, or divisor magnitude
   logic                 neg_q, div0, div_ovf;
   logic [CNT_W-1:0]     count;
   logic                 term;

   logic                 accept;
   logic [WIDTH-1:0]     a_mag, b_mag;
   logic [WIDTH:0]       hi_ext, m_ext, b_sum;
   logic [2*WIDTH-1:0]   mult_next, div_next;
   logic [WIDTH:0]       trial;
   logic [WIDTH-1:0]     sub;
   logic                 ge;
   logic                 mult_ovf;
   logic [WIDTH-1:0]     fix_result;
   logic                 fix_exc;

   // A new op may be taken from IDLE or during the ready cycle; abort always wins.
   assign accept = (state == IDLE || state == DONE) && (start_mult || start_div) && !abort;

   assign a_mag = operand_a[WIDTH-1] ? -operand_a : operand_a;
   assign b_mag = operand_b[WIDTH-1] ? -operand_b : operand_b;

   multdiv_step_ctr #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_ctr (
      .clock    (clock),
      .reset    (reset),
      .clear    (abort),
      .load     (accept),
      .en       (state == MULT || state == DIV),
      .load_val ('0),
      .count    (count),
      .term     (term)
   );

   // Booth step: add/sub in WIDTH+1 bits so MIN_INT operands cannot overflow.
   assign hi_ext = {acc[2*WIDTH-1], acc[2*WIDTH-1:WIDTH]};
   assign m_ext  = {opnd[WIDTH-1], opnd};

   always_comb begin
      b_sum = hi_ext;
      case ({acc[0], qm1})
         2'b01:   b_sum = hi_ext + m_ext;
         2'b10:   b_sum = hi_ext - m_ext;
         default: b_sum = hi_ext;
      endcase
   end

   assign mult_next = {b_sum[WIDTH:1], b_sum[0], acc[WIDTH-1:1]};
   assign mult_ovf  = (acc[2*WIDTH-1:WIDTH] != {WIDTH{acc[WIDTH-1]}});

   // Restoring step: shift next dividend bit into the partial remainder and trial-subtract.
   assign trial    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
   assign ge       = (trial >= {1'b0, opnd});
   assign sub      = trial[WIDTH-1:0] - opnd;
   assign div_next = ge ? {sub, acc[WIDTH-2:0], 1'b1}
                        : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};

   always_comb begin
      fix_result = acc[WIDTH-1:0];
      fix_exc    = mult_ovf;
      if (op == OP_DIV) begin
         if (div0) begin
            fix_result = '0;
            fix_exc    = 1'b1;
         end else if (div_ovf) begin
            fix_result = MIN_INT;
            fix_exc    = 1'b1;
         end else begin
            fix_result = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
            fix_exc    = 1'b0;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         acc     <= '0;
         qm1     <= 1'b0;
         opnd    <= '0;
         op      <= OP_MULT;
         neg_q   <= 1'b0;
         div0    <= 1'b0;
         div_ovf <= 1'b0;
      end else if (accept) begin
         qm1 <= 1'b0;
         if (start_mult) begin
            op   <= OP_MULT;
            acc  <= {{WIDTH{1'b0}}, operand_b};
            opnd <= operand_a;
         end else begin
            op      <= OP_DIV;
            acc     <= {{WIDTH{1'b0}}, a_mag};
            opnd    <= b_mag;
            neg_q   <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
            div0    <= (operand_b == '0);
            div_ovf <= (operand_a == MIN_INT) && (operand_b == '1);
         end
      end else if (state == MULT) begin
         acc <= mult_next;
         qm1 <= acc[0];
      end else if (state == DIV) begin
         acc <= div_next;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         busy      <= 1'b0;
         ready     <= 1'b0;
         result    <= '0;
         exception <= 1'b0;
      end else begin
         ready <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (accept) begin
                  state <= start_mult ? MULT : DIV;
                  busy  <= 1'b1;
               end else begin
                  state <= IDLE;
               end
            end
            MULT, DIV: begin
               if (abort) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (term) begin
                  state <= FIX;
               end
            end
            FIX: begin
               busy <= 1'b0;
               if (abort) begin
                  state <= IDLE;
               end else begin
                  state     <= DONE;
                  ready     <= 1'b1;
                  result    <= fix_result;
                  exception <= fix_exc;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef MULTDIV_REM_EN
   logic             neg_r;
   logic [WIDTH-1:0] rem_fix;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)                   neg_r <= 1'b0;
      else if (accept && !start_mult) neg_r <= operand_a[WIDTH-1];
   end

   always_comb begin
      rem_fix = '0;
      if (op == OP_DIV && !div0 && !div_ovf)
         rem_fix = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)                      remainder <= '0;
      else if (state == FIX && !abort) remainder <= rem_fix;
   end
`endif

endmodule
